seq_adder_n: RTL and testbench

SEQ_ADDER_N -- requirements
Module: seq_adder_n

---
 rtl/seq_adder_n.sv | 114 +++++++++++
 tb/tb_seq_adder_n.sv | 133 +++++++++++++
 2 files changed

// File: rtl/seq_adder_n.sv
// rtl/seq_adder_n.sv - digit-serial adder/subtractor, DIGIT bits per clock
// Operands shift right one digit per RUN cycle; the result shifts in from the top.
module seq_adder_n #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             ovf,
    output logic             busy,
    output logic             done
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d, res_next;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic             c_q, c_d, ovf_q, ovf_d;
    logic [KW-1:0]    k_q, k_d;
    logic [DIGIT:0]   dsum;
    logic             last;

    assign dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    assign last = (k_q == KW'(NDIG - 1));

    generate
        if (DIGIT == WIDTH) begin : g_single
            assign res_next = dsum[DIGIT-1:0];
        end else begin : g_multi
            assign res_next = {dsum[DIGIT-1:0], res_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            c_q     <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        s_d     = s_q;
        carry_d = carry_q;
        c_d     = c_q;
        ovf_d   = ovf_q;
        k_d     = k_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    k_d     = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dsum[DIGIT];
                res_d   = res_next;
                k_d     = k_q + 1'b1;
                if (last) begin
                    // Carry into the MSB is recovered from the MSB's sum bit.
                    state_d = DONE;
                    s_d     = res_next;
                    c_d     = dsum[DIGIT];
                    ovf_d   = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1] ^ dsum[DIGIT];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s    = s_q;
    assign c    = c_q;
    assign ovf  = ovf_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
endmodule

// File: tb/tb_seq_adder_n.sv
// tb/tb_seq_adder_n.sv - directed self-checking bench for seq_adder_n
module tb_seq_adder_n;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // u0: 8/4, u1: 8/1, u2: 4/4
    logic       start0 = 0, sub0 = 0;
    logic [7:0] a0 = 0, b0 = 0, s0;
    logic       c0, ovf0, busy0, done0;
    logic       start1 = 0, sub1 = 0;
    logic [7:0] a1 = 0, b1 = 0, s1;
    logic       c1, ovf1, busy1, done1;
    logic       start2 = 0, sub2 = 0;
    logic [3:0] a2 = 0, b2 = 0, s2;
    logic       c2, ovf2, busy2, done2;

    seq_adder_n #(.WIDTH(8), .DIGIT(4)) u0 (
        .clk(clk), .rst(rst), .start(start0), .sub(sub0), .a(a0), .b(b0),
        .s(s0), .c(c0), .ovf(ovf0), .busy(busy0), .done(done0));
    seq_adder_n #(.WIDTH(8), .DIGIT(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .s(s1), .c(c1), .ovf(ovf1), .busy(busy1), .done(done1));
    seq_adder_n #(.WIDTH(4), .DIGIT(4)) u2 (
        .clk(clk), .rst(rst), .start(start2), .sub(sub2), .a(a2), .b(b2),
        .s(s2), .c(c2), .ovf(ovf2), .busy(busy2), .done(done2));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] flags0();
        return {s0, c0, ovf0, busy0};
    endfunction

    // Full 8/4 operation: start at a negedge, observe busy, done and results.
    task automatic op0(input string tag, input logic sb, input logic [7:0] ea, input logic [7:0] eb,
                       input logic [7:0] es, input logic ec, input logic eo);
        logic [7:0] prev_s;
        prev_s = s0;
        start0 = 1; sub0 = sb; a0 = ea; b0 = eb;
        @(negedge clk);
        start0 = 0;
        check({tag, "_busy1"}, {busy0, done0, s0}, {1'b1, 1'b0, prev_s});
        @(negedge clk);
        check({tag, "_busy2"}, {busy0, done0}, 2'b10);
        @(negedge clk);
        check({tag, "_done"}, {busy0, done0, s0, c0, ovf0}, {1'b0, 1'b1, es, ec, eo});
        @(negedge clk);
        check({tag, "_idle"}, {busy0, done0}, 2'b00);
    endtask

    initial begin
        int cnt;
        #2;
        check("reset_async", {flags0(), done0}, 12'h000);
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        op0("add_09_0c", 0, 8'h09, 8'h0C, 8'h15, 0, 0);
        op0("add_ff_01", 0, 8'hFF, 8'h01, 8'h00, 1, 0);
        op0("add_7f_01", 0, 8'h7F, 8'h01, 8'h80, 0, 1);
        op0("sub_03_0a", 1, 8'h03, 8'h0A, 8'hF9, 0, 0);
        op0("sub_80_01", 1, 8'h80, 8'h01, 8'h7F, 1, 1);

        // Restart and operand changes during RUN are ignored; then back-to-back.
        start0 = 1; sub0 = 0; a0 = 8'h12; b0 = 8'h34;
        @(negedge clk);
        start0 = 1; sub0 = 1; a0 = 8'hFF; b0 = 8'hEE;
        @(negedge clk);
        start0 = 0;
        @(negedge clk);
        check("ignore_run_done", {done0, s0, c0, ovf0}, {1'b1, 8'h46, 1'b0, 1'b0});
        start0 = 1; sub0 = 0; a0 = 8'h50; b0 = 8'h50;
        @(negedge clk);
        start0 = 0;
        check("b2b_busy", {busy0, done0, s0}, {1'b1, 1'b0, 8'h46});
        @(negedge clk);
        check("b2b_busy2", {busy0, done0}, 2'b10);
        @(negedge clk);
        check("b2b_done", {done0, s0, c0, ovf0}, {1'b1, 8'hA0, 1'b0, 1'b1});
        @(negedge clk);

        // Reset mid-RUN: outputs clear at once, no done follows.
        start0 = 1; sub0 = 0; a0 = 8'h01; b0 = 8'h02;
        @(negedge clk);
        start0 = 0;
        #2 rst = 1;
        #1 check("rst_midrun", {flags0(), done0}, 12'h000);
        @(negedge clk);
        rst = 0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done0 || busy0) cnt++;
        end
        check("rst_no_done", cnt, 0);
        op0("add_22_11", 0, 8'h22, 8'h11, 8'h33, 0, 0);

        // 8/1: one bit per cycle.
        start1 = 1; a1 = 8'hAA; b1 = 8'h55;
        @(negedge clk);
        start1 = 0;
        cnt = 0;
        for (int i = 0; i < 20 && !done1; i++) begin
            if (busy1) cnt++;
            @(negedge clk);
        end
        check("d1_busy_cycles", cnt, 8);
        check("d1_result", {done1, s1, c1, ovf1}, {1'b1, 8'hFF, 1'b0, 1'b0});

        // 4/4: single-cycle operation.
        start2 = 1; a2 = 4'h9; b2 = 4'hC;
        @(negedge clk);
        start2 = 0;
        check("d4_busy", {busy2, done2}, 2'b10);
        @(negedge clk);
        check("d4_result", {done2, s2, c2, ovf2}, {1'b1, 4'h5, 1'b1, 1'b1});
        @(negedge clk);
        check("d4_idle", {busy2, done2, s2}, {1'b0, 1'b0, 4'h5});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
